// File: rtl/methane_pkg.sv
// Shared definitions for the load/store unit: memory op encodings, FSM states,
// access-size codes and byte-enable masks.
package methane_pkg;

   // {is_store, funct3} encodings of the supported memory operations
   typedef enum logic [3:0] {
      OP_LB  = 4'b0000,
      OP_LH  = 4'b0001,
      OP_LW  = 4'b0010,
      OP_LBU = 4'b0100,
      OP_LHU = 4'b0101,
      OP_SB  = 4'b1000,
      OP_SH  = 4'b1001,
      OP_SW  = 4'b1010
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } lsu_state_t;

   // Access size is funct3[1:0]
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Byte-enable masks before shifting to the addressed lane
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // True for the eight defined encodings, false for everything else
   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering.
// Store side: replicates store data into every lane and builds the write mask.
// Load side: shifts the addressed lane down and sign/zero extends it.
// The offset must already be naturally aligned for the access size.
module lsu_lane_align
   import methane_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  we_mask,
   output logic [31:0] din,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   // Lane steering for both directions, selected by access size
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      we_mask   = BE_WORD;
      din       = wdata;
      load_data = 32'd0;
      shifted   = rdata >> {offset, 3'b000};
      case (size)
         SIZE_BYTE: begin
            we_mask   = BE_BYTE << offset;
            din       = {4{wdata[7:0]}};
            load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            we_mask   = BE_HALF << offset;
            din       = {2{wdata[15:0]}};
            load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: begin
            we_mask   = BE_WORD;
            din       = wdata;
            load_data = shifted;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store stage in front of a word-wide
// BRAM port. FSM IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE, all outputs registered.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip memory
// and respond with resp_err=1. Without it, low address bits are forced to
// natural alignment and the access proceeds.
module load_store_unit
   import methane_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);

   localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

   lsu_state_t  state;
   logic [3:0]  op_q;
   logic [1:0]  off_q;
   logic        err_q;
   logic [1:0]  cnt;

   logic [1:0]  req_size;
   logic [1:0]  off_aligned;
   logic        misalign;
   logic        bad_req;

   logic [1:0]  al_size;
   logic [1:0]  al_offset;
   logic [3:0]  al_we_mask;
   logic [31:0] al_din;
   logic [31:0] al_load_data;

   // Address bits above the BRAM range wrap around and are deliberately dropped
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   // Classify the incoming request: aligned lane offset and error conditions
   always_comb begin
      req_size    = req_op[1:0];
      off_aligned = req_addr[1:0];
      case (req_size)
         SIZE_HALF: off_aligned = {req_addr[1], 1'b0};
         SIZE_WORD: off_aligned = 2'b00;
         default:   off_aligned = req_addr[1:0];
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                 ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      bad_req = !op_legal(req_op) || misalign;
   end

   // In IDLE the aligner sees the live request (store path); later the latched one
   always_comb begin
      al_size   = (state == IDLE) ? req_size    : op_q[1:0];
      al_offset = (state == IDLE) ? off_aligned : off_q;
   end

   lsu_lane_align u_lane_align (
      .size        (al_size),
      .is_unsigned (op_q[2]),
      .offset      (al_offset),
      .wdata       (req_wdata),
      .rdata       (mem_dout),
      .we_mask     (al_we_mask),
      .din         (al_din),
      .load_data   (al_load_data)
   );

   // Access FSM with registered handshake, memory and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_data  <= 32'd0;
         resp_err   <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 4'b0000;
         mem_addr   <= '0;
         mem_din    <= 32'd0;
         op_q       <= OP_LB;
         off_q      <= 2'b00;
         err_q      <= 1'b0;
         cnt        <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  off_q     <= off_aligned;
                  err_q     <= bad_req;
                  mem_addr  <= req_addr[ADDR_W+1:2];
                  req_ready <= 1'b0;
                  state     <= ISSUE;
                  if (!bad_req) begin
                     mem_en <= 1'b1;
                     if (req_op[3]) begin
                        mem_we  <= al_we_mask;
                        mem_din <= al_din;
                     end
                  end
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 4'b0000;
               if (err_q || op_q[3]) begin
                  resp_valid <= 1'b1;
                  resp_err   <= err_q;
                  resp_data  <= 32'd0;
                  state      <= RESP;
               end else begin
                  cnt   <= WAIT_INIT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 2'd0) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_data  <= al_load_data;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural BRAM
// (read-first, one-cycle read latency). Honours LSU_MISALIGN_TRAP_EN if defined.
module tb_load_store_unit;

   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [3:0]        req_op = 4'd0;
   logic [31:0]       req_addr = 32'd0;
   logic [31:0]       req_wdata = 32'd0;
   logic              resp_valid;
   logic [31:0]       resp_data;
   logic              resp_err;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic [31:0]       mem_dout = 32'd0;

   int n_checks = 0;
   int n_pass   = 0;

   // Bus monitor state
   int          en_cnt = 0;
   int          resp_cnt = 0;
   logic [3:0]  last_we = 4'd0;
   logic [31:0] last_addr = 32'd0;
   logic [31:0] last_din = 32'd0;

   logic [31:0] bram [0:(1<<ADDR_W)-1];

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(ADDR_W), .RD_LATENCY(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   // Behavioural BRAM: byte-lane writes, read-first data one cycle later
   always @(posedge clk) begin
      if (mem_en) begin
         for (int i = 0; i < 4; i++)
            if (mem_we[i]) bram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
         mem_dout <= bram[mem_addr];
      end
   end

   // Record every memory access and response pulse
   always @(posedge clk) begin
      if (mem_en) begin
         en_cnt++;
         last_we   = mem_we;
         last_addr = 32'(mem_addr);
         last_din  = mem_din;
      end
      if (resp_valid) resp_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   // One complete request; lat counts cycles from the request cycle to resp_valid
   task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output logic err, output int lat);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      data = resp_data;
      err  = resp_err;
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          lat;
      int          en_before;
      int          resp_before;

      for (int i = 0; i < (1 << ADDR_W); i++) bram[i] = 32'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready",  32'(req_ready),  32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data",  resp_data,       32'd0);
      check("rst_resp_err",   32'(resp_err),   32'd0);
      check("rst_mem_en",     32'(mem_en),     32'd0);
      check("rst_mem_we",     32'(mem_we),     32'd0);
      check("rst_mem_addr",   32'(mem_addr),   32'd0);
      check("rst_mem_din",    mem_din,         32'd0);
      rst = 1'b0;

      // 1: SW then LW at 0x100
      do_req(4'b1010, 32'h0000_0100, 32'hDEAD_BEEF, d, e, lat);
      check("sw_we",    32'(last_we), 32'h0000_000F);
      check("sw_addr",  last_addr,    32'h0000_0040);
      check("sw_din",   last_din,     32'hDEAD_BEEF);
      check("sw_lat",   32'(lat),     32'd2);
      check("sw_err",   32'(e),       32'd0);
      check("sw_data",  d,            32'd0);
      do_req(4'b0010, 32'h0000_0100, 32'd0, d, e, lat);
      check("lw_data",  d,            32'hDEAD_BEEF);
      check("lw_lat",   32'(lat),     32'd3);
      check("lw_addr",  last_addr,    32'h0000_0040);
      check("lw_we",    32'(last_we), 32'd0);

      // 2: byte store/loads in lane 3
      do_req(4'b1000, 32'h0000_0103, 32'h0000_0080, d, e, lat);
      check("sb_we",    32'(last_we), 32'h0000_0008);
      check("sb_din",   last_din,     32'h8080_8080);
      do_req(4'b0000, 32'h0000_0103, 32'd0, d, e, lat);
      check("lb_data",  d,            32'hFFFF_FF80);
      do_req(4'b0100, 32'h0000_0103, 32'd0, d, e, lat);
      check("lbu_data", d,            32'h0000_0080);

      // 3: half store/loads in upper half
      do_req(4'b1001, 32'h0000_0102, 32'h0000_8001, d, e, lat);
      check("sh_we",    32'(last_we), 32'h0000_000C);
      check("sh_din",   last_din,     32'h8001_8001);
      do_req(4'b0001, 32'h0000_0102, 32'd0, d, e, lat);
      check("lh_data",  d,            32'hFFFF_8001);
      do_req(4'b0101, 32'h0000_0102, 32'd0, d, e, lat);
      check("lhu_data", d,            32'h0000_8001);
      do_req(4'b0010, 32'h0000_0100, 32'd0, d, e, lat);
      check("lw_merge", d,            32'h8001_BEEF);

      // 4: misaligned word load
      en_before = en_cnt;
      do_req(4'b0010, 32'h0000_0102, 32'd0, d, e, lat);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_err",  32'(e),       32'd1);
      check("mis_data", d,            32'd0);
      check("mis_en",   32'(en_cnt - en_before), 32'd0);
`else
      check("mis_err",  32'(e),       32'd0);
      check("mis_data", d,            32'h8001_BEEF);
      check("mis_en",   32'(en_cnt - en_before), 32'd1);
`endif

      // 5: illegal op and address wrap
      en_before = en_cnt;
      do_req(4'b0011, 32'h0000_0100, 32'd0, d, e, lat);
      check("ill_err",  32'(e),       32'd1);
      check("ill_data", d,            32'd0);
      check("ill_en",   32'(en_cnt - en_before), 32'd0);
      en_before = en_cnt;
      do_req(4'b1011, 32'h0000_0100, 32'h1111_1111, d, e, lat);
      check("ills_err", 32'(e),       32'd1);
      check("ills_en",  32'(en_cnt - en_before), 32'd0);
      do_req(4'b0010, 32'h0001_0100, 32'd0, d, e, lat);
      check("wrap_data", d,           32'h8001_BEEF);
      check("wrap_addr", last_addr,   32'h0000_0040);
      check("wrap_err",  32'(e),      32'd0);

      // 6: reset during WAIT of a load
      @(negedge clk);
      resp_before = resp_cnt;
      req_op    = 4'b0010;
      req_addr  = 32'h0000_0100;
      req_valid = 1'b1;
      @(negedge clk);              // ISSUE
      req_valid = 1'b0;
      @(negedge clk);              // WAIT
      rst = 1'b1;
      @(negedge clk);
      check("rstw_ready", 32'(req_ready),  32'd1);
      check("rstw_valid", 32'(resp_valid), 32'd0);
      check("rstw_en",    32'(mem_en),     32'd0);
      check("rstw_we",    32'(mem_we),     32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rstw_noresp", 32'(resp_cnt - resp_before), 32'd0);
      do_req(4'b1010, 32'h0000_0104, 32'h1234_5678, d, e, lat);
      check("post_sw_lat", 32'(lat),   32'd2);
      check("post_sw_err", 32'(e),     32'd0);
      do_req(4'b0010, 32'h0000_0104, 32'd0, d, e, lat);
      check("post_lw_data", d,         32'h1234_5678);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
